// File: rtl/iter_alu_pkg.sv
// Shared types for the iterative ALU: operation encoding, FSM states and op-class helpers.
package iter_alu_pkg;

  typedef enum logic [4:0] {
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE, ST_MUL, ST_DIV, ST_DONE
  } state_t;

  function automatic logic is_mul(input alu_op_t op);
    return op inside {MUL, MULH, MULHSU, MULHU};
  endfunction

  function automatic logic is_div(input alu_op_t op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

endpackage

// File: rtl/iter_alu_if.sv
// Request/response bundle between the execute-stage control (master) and the ALU (slave).
interface iter_alu_if
  import iter_alu_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  alu_op_t          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, negative, zero, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, negative, zero, busy
  );

endinterface

// File: rtl/iter_alu_core.sv
// Combinational single-cycle datapath for the base integer ops; o_is_base flags ops it handles.
module iter_alu_core
  import iter_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_op_t          i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_is_base
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0] w_shamt;
  assign w_shamt = i_b[SHW-1:0];

  always_comb begin
    o_result  = '0;
    o_is_base = 1'b1;
    case (i_op)
      ADD:  o_result = i_a + i_b;
      SUB:  o_result = i_a - i_b;
      SLL:  o_result = i_a << w_shamt;
      SRL:  o_result = i_a >> w_shamt;
      SRA:  o_result = $unsigned($signed(i_a) >>> w_shamt);
      SLT:  o_result = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      SLTU: o_result = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
      XOR:  o_result = i_a ^ i_b;
      OR:   o_result = i_a | i_b;
      AND:  o_result = i_a & i_b;
      default: o_is_base = 1'b0;
    endcase
  end

endmodule

// File: rtl/iter_alu.sv
// Multi-cycle ALU: base ops in 1 cycle, bit-serial MUL*/DIV*/REM* in WIDTH+1; result held until out_ready.
// ITER_ALU_EARLY_OUT_EN: MUL* stops as soon as the remaining multiplier bits are all zero.
module iter_alu
  import iter_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      nRst,
  input  logic      flush,
  iter_alu_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             r_state, w_state_nxt;
  alu_op_t            r_op;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic [SHW-1:0]     r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_result;
  logic               r_negative;
  logic               r_zero;

  logic             w_op_mul, w_op_div;
  logic             w_a_neg, w_b_neg;
  logic             w_div_zero, w_div_ovf, w_div_spec;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_spec_res;
  logic [WIDTH-1:0] w_core_res;
  logic             w_core_base;

  assign w_op_mul   = is_mul(bus.op);
  assign w_op_div   = is_div(bus.op);
  assign w_a_neg    = (bus.op inside {MUL, MULH, MULHSU, DIV, REM}) && bus.a[WIDTH-1];
  assign w_b_neg    = (bus.op inside {MUL, MULH, DIV, REM}) && bus.b[WIDTH-1];
  assign w_a_mag    = w_a_neg ? -bus.a : bus.a;
  assign w_b_mag    = w_b_neg ? -bus.b : bus.b;
  assign w_div_zero = (bus.b == '0);
  assign w_div_ovf  = (bus.op inside {DIV, REM}) && (bus.a == MIN_VAL) && (bus.b == '1);
  assign w_div_spec = w_op_div && (w_div_zero || w_div_ovf);
  assign w_spec_res = (bus.op inside {DIV, DIVU}) ? (w_div_zero ? '1 : MIN_VAL)
                                                  : (w_div_zero ? bus.a : '0);

  iter_alu_core #(.WIDTH(WIDTH)) u_core (
    .i_op      (bus.op),
    .i_a       (bus.a),
    .i_b       (bus.b),
    .o_result  (w_core_res),
    .o_is_base (w_core_base)
  );

  // Shift-add step; the sign fix is folded into the last step so no extra cycle is spent.
  logic [2*WIDTH-1:0] w_acc_sum, w_mul_fix;
  logic [WIDTH-1:0]   w_mul_res;
  logic               w_mul_last, w_cnt_last;

  assign w_acc_sum  = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_fix  = r_neg_res ? -w_acc_sum : w_acc_sum;
  assign w_mul_res  = (r_op == MUL) ? w_mul_fix[WIDTH-1:0] : w_mul_fix[2*WIDTH-1:WIDTH];
  assign w_cnt_last = (r_cnt == CNT_LAST);

`ifdef ITER_ALU_EARLY_OUT_EN
  assign w_mul_last = w_cnt_last || (r_mplier[WIDTH-1:1] == '0);
`else
  assign w_mul_last = w_cnt_last;
`endif

  // Restoring division: r_mplier doubles as dividend-in / quotient-out shift register.
  logic [WIDTH:0]   w_rem_sh;
  logic             w_rem_ge;
  logic [WIDTH-1:0] w_rem_dif, w_rem_nxt, w_quo_nxt, w_div_res;

  assign w_rem_sh  = {r_rem, r_mplier[WIDTH-1]};
  assign w_rem_ge  = (w_rem_sh >= {1'b0, r_divisor});
  assign w_rem_dif = w_rem_sh[WIDTH-1:0] - r_divisor;
  assign w_rem_nxt = w_rem_ge ? w_rem_dif : w_rem_sh[WIDTH-1:0];
  assign w_quo_nxt = {r_mplier[WIDTH-2:0], w_rem_ge};
  assign w_div_res = (r_op inside {DIV, DIVU}) ? (r_neg_res ? -w_quo_nxt : w_quo_nxt)
                                               : (r_neg_rem ? -w_rem_nxt : w_rem_nxt);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (w_op_mul)                     w_state_nxt = ST_MUL;
          else if (w_op_div && !w_div_spec) w_state_nxt = ST_DIV;
          else                              w_state_nxt = ST_DONE;
        end
      end
      ST_MUL:  if (w_mul_last)    w_state_nxt = ST_DONE;
      ST_DIV:  if (w_cnt_last)    w_state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (flush) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!nRst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  logic             w_wr_en;
  logic [WIDTH-1:0] w_wr_val;

  always_comb begin
    w_wr_en  = 1'b0;
    w_wr_val = '0;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (w_core_base) begin
            w_wr_en  = 1'b1;
            w_wr_val = w_core_res;
          end else if (w_div_spec) begin
            w_wr_en  = 1'b1;
            w_wr_val = w_spec_res;
          end else if (!w_op_mul && !w_op_div) begin
            w_wr_en  = 1'b1;  // undefined op code completes with zero
          end
        end
      end
      ST_MUL: begin
        w_wr_en  = w_mul_last;
        w_wr_val = w_mul_res;
      end
      ST_DIV: begin
        w_wr_en  = w_cnt_last;
        w_wr_val = w_div_res;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst || flush) begin
      r_op       <= ADD;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_rem      <= '0;
      r_divisor  <= '0;
      r_result   <= '0;
      r_negative <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_result   <= w_wr_val;
        r_negative <= w_wr_val[WIDTH-1];
        r_zero     <= (w_wr_val == '0);
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_op      <= bus.op;
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= {{WIDTH{1'b0}}, w_a_mag};
            r_mplier  <= w_op_div ? w_a_mag : w_b_mag;
            r_rem     <= '0;
            r_divisor <= w_b_mag;
          end
        end
        ST_MUL: begin
          r_acc    <= w_acc_sum;
          r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
          r_cnt    <= r_cnt + SHW'(1);
        end
        ST_DIV: begin
          r_rem    <= w_rem_nxt;
          r_mplier <= w_quo_nxt;
          r_cnt    <= r_cnt + SHW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.busy      = (r_state == ST_MUL) || (r_state == ST_DIV);
  assign bus.result    = r_result;
  assign bus.negative  = r_negative;
  assign bus.zero      = r_zero;

endmodule
